// File: rtl/register32_8_reader_pkg.sv
// Shared widths and FSM encoding for the 8 x 32-bit register file reader.
// Imported by the reader top level and its 8:1 read mux.
package register32_8_reader_pkg;

   localparam int REG_DATA_WIDTH = 32;
   localparam int REG_ADDR_WIDTH = 3;
   localparam int REG_LEN_WIDTH  = 3;
   localparam int REG_NUM        = 2 ** REG_ADDR_WIDTH;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BEAT = 1'b1
   } state_t;

endpackage

// File: rtl/register32_8_reader_mux8.sv
// Combinational 8:1 select over the register file outputs.
// Ports: d_in0..d_in7 register values, sel index, q selected word.
module register32_8_reader_mux8
   import register32_8_reader_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]     d_in0,
   input  logic [DATA_WIDTH-1:0]     d_in1,
   input  logic [DATA_WIDTH-1:0]     d_in2,
   input  logic [DATA_WIDTH-1:0]     d_in3,
   input  logic [DATA_WIDTH-1:0]     d_in4,
   input  logic [DATA_WIDTH-1:0]     d_in5,
   input  logic [DATA_WIDTH-1:0]     d_in6,
   input  logic [DATA_WIDTH-1:0]     d_in7,
   input  logic [REG_ADDR_WIDTH-1:0] sel,
   output logic [DATA_WIDTH-1:0]     q
);

   always_comb begin
      q = '0;
      unique case (sel)
         3'd0: q = d_in0;
         3'd1: q = d_in1;
         3'd2: q = d_in2;
         3'd3: q = d_in3;
         3'd4: q = d_in4;
         3'd5: q = d_in5;
         3'd6: q = d_in6;
         3'd7: q = d_in7;
      endcase
   end

endmodule

// File: rtl/register32_8_reader.sv
// Read-side controller for the 8 x 32-bit register file: single/burst
// requests over rd_req/rd_ack, registered beats over rd_valid/rd_ready.
// Ports: clk, reset_n (async low); rd_req, rd_addr, rd_len, rd_ack;
// d_in0..d_in7 register outputs; rd_data, rd_valid, rd_last, rd_ready;
// busy (high outside IDLE).
module register32_8_reader
   import register32_8_reader_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int LEN_WIDTH  = REG_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [LEN_WIDTH-1:0]  rd_len,
   output logic                  rd_ack,
   input  logic [DATA_WIDTH-1:0] d_in0,
   input  logic [DATA_WIDTH-1:0] d_in1,
   input  logic [DATA_WIDTH-1:0] d_in2,
   input  logic [DATA_WIDTH-1:0] d_in3,
   input  logic [DATA_WIDTH-1:0] d_in4,
   input  logic [DATA_WIDTH-1:0] d_in5,
   input  logic [DATA_WIDTH-1:0] d_in6,
   input  logic [DATA_WIDTH-1:0] d_in7,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   input  logic                  rd_ready,
   output logic                  busy
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH-1:0] ptr_nxt;
   logic [ADDR_WIDTH-1:0] sel;
   logic [LEN_WIDTH-1:0]  cnt;
   logic [DATA_WIDTH-1:0] mux_q;

   // Natural ADDR_WIDTH wrap gives 7 -> 0 for free.
   assign ptr_nxt = ptr + ADDR_WIDTH'(1);

   // IDLE launches the first beat from rd_addr; BEAT prefetches ptr+1.
   assign sel = (state == ST_IDLE) ? rd_addr : ptr_nxt;

   register32_8_reader_mux8 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .d_in0 (d_in0),
      .d_in1 (d_in1),
      .d_in2 (d_in2),
      .d_in3 (d_in3),
      .d_in4 (d_in4),
      .d_in5 (d_in5),
      .d_in6 (d_in6),
      .d_in7 (d_in7),
      .sel   (sel),
      .q     (mux_q)
   );

   // rd_ack is registered: low through reset, rises on the first edge
   // after release, drops on accept, and rises again only in the cycle
   // after the last-beat edge, so no request is taken on that edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         cnt      <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         busy     <= 1'b0;
         rd_ack   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               rd_ack <= 1'b1;
               if (rd_req && rd_ack) begin
                  ptr      <= rd_addr;
                  cnt      <= rd_len;
                  rd_data  <= mux_q;
                  rd_valid <= 1'b1;
                  rd_last  <= (rd_len == '0);
                  busy     <= 1'b1;
                  rd_ack   <= 1'b0;
                  state    <= ST_BEAT;
               end
            end
            ST_BEAT: begin
               // rd_valid is always high here; !rd_ready holds everything.
               if (rd_ready) begin
                  if (cnt != '0) begin
                     ptr     <= ptr_nxt;
                     cnt     <= cnt - LEN_WIDTH'(1);
                     rd_data <= mux_q;
                     rd_last <= (cnt == LEN_WIDTH'(1));
                  end else begin
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                     busy     <= 1'b0;
                     rd_ack   <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_register32_8_reader.sv
// Self-checking bench for register32_8_reader: vector table of bursts,
// scoreboard of expected beats, hand sequences for stall/reset corners.
module tb_register32_8_reader;

   typedef struct {
      logic [2:0]  addr;
      logic [2:0]  len;
      logic [7:0]  pat;
      logic [31:0] first;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic        rd_req;
   logic [2:0]  rd_addr;
   logic [2:0]  rd_len;
   logic        rd_ack;
   logic [31:0] d [8];
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_last;
   logic        rd_ready;
   logic        busy;

   logic [32:0] sb [$];
   int          npass;
   int          ntotal;

   register32_8_reader dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_len   (rd_len),
      .rd_ack   (rd_ack),
      .d_in0    (d[0]),
      .d_in1    (d[1]),
      .d_in2    (d[2]),
      .d_in3    (d[3]),
      .d_in4    (d[4]),
      .d_in5    (d[5]),
      .d_in6    (d[6]),
      .d_in7    (d[7]),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_last  (rd_last),
      .rd_ready (rd_ready),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [32:0] act,
                      input logic [32:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Scoreboard consumer: a beat transfers when valid&ready at the edge.
   always @(negedge clk) begin
      if (reset_n && rd_valid && rd_ready) begin
         if (sb.size() == 0) begin
            ntotal++;
            $display("FAIL extra_beat: got %h last %b, expected none",
                     rd_data, rd_last);
         end else begin
            chk("beat", {rd_last, rd_data}, sb.pop_front());
         end
      end
   end

   task automatic wait_ack();
      int n;
      n = 0;
      while (!rd_ack && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rd_ack) chk("ack_timeout", 33'(rd_ack), 33'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(sb.size() == 0 && !busy) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("idle_timeout", 33'(busy), 33'd0);
   endtask

   task automatic do_burst(input vec_t v);
      int cyc;
      wait_ack();
      rd_addr = v.addr;
      rd_len  = v.len;
      rd_req  = 1'b1;
      sb.push_back({v.len == 3'd0, v.first});
      for (int i = 1; i <= int'(v.len); i++)
         sb.push_back({i == int'(v.len), d[(int'(v.addr) + i) % 8]});
      @(posedge clk); #1;
      rd_req = 1'b0;
      cyc = 0;
      while (!(sb.size() == 0 && !busy) && cyc < 200) begin
         rd_ready = v.pat[cyc % 8];
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 200) chk("burst_timeout", 33'(busy), 33'd0);
      else if (v.pat == 8'hff)
         chk("burst_cycles", 33'(cyc), 33'(int'(v.len) + 1));
      rd_ready = 1'b1;
   endtask

   vec_t vecs [6];

   initial begin
      int n;
      npass    = 0;
      ntotal   = 0;
      reset_n  = 1'b0;
      rd_req   = 1'b0;
      rd_addr  = '0;
      rd_len   = '0;
      rd_ready = 1'b1;
      for (int k = 0; k < 8; k++) d[k] = 32'h1000_0000 | k;

      vecs[0] = '{addr: 3'd6, len: 3'd3, pat: 8'hff, first: 32'h1000_0006};
      vecs[1] = '{addr: 3'd0, len: 3'd7, pat: 8'hff, first: 32'h1000_0000};
      vecs[2] = '{addr: 3'd5, len: 3'd7, pat: 8'hff, first: 32'h1000_0005};
      vecs[3] = '{addr: 3'd2, len: 3'd2, pat: 8'haa, first: 32'h1000_0002};
      vecs[4] = '{addr: 3'd7, len: 3'd0, pat: 8'hf0, first: 32'h1000_0007};
      vecs[5] = '{addr: 3'd1, len: 3'd4, pat: 8'h6d, first: 32'h1000_0001};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 33'(rd_valid), 33'd0);
      chk("rst_last", 33'(rd_last), 33'd0);
      chk("rst_busy", 33'(busy), 33'd0);
      chk("rst_data", 33'(rd_data), 33'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_ack", 33'(rd_ack), 33'd1);

      // Single read
      d[3] = 32'h00ff00ff;
      rd_addr = 3'd3;
      rd_len  = 3'd0;
      rd_req  = 1'b1;
      sb.push_back({1'b1, 32'h00ff00ff});
      @(posedge clk); #1;
      rd_req = 1'b0;
      chk("single_data", 33'(rd_data), 33'h00ff00ff);
      chk("single_valid", 33'(rd_valid), 33'd1);
      chk("single_last", 33'(rd_last), 33'd1);
      chk("single_ack_low", 33'(rd_ack), 33'd0);
      chk("single_busy", 33'(busy), 33'd1);
      @(posedge clk); #1;
      chk("single_done_valid", 33'(rd_valid), 33'd0);
      chk("single_done_ack", 33'(rd_ack), 33'd1);
      chk("single_done_busy", 33'(busy), 33'd0);
      chk("idle_keeps_data", 33'(rd_data), 33'h00ff00ff);
      d[3] = 32'h1000_0003;

      // Table bursts (wrap, full 8, random back-pressure)
      foreach (vecs[i]) do_burst(vecs[i]);

      // Stall on beat 2 while d_in7 changes
      wait_ack();
      rd_addr = 3'd6;
      rd_len  = 3'd3;
      rd_req  = 1'b1;
      sb.push_back({1'b0, 32'h1000_0006});
      sb.push_back({1'b0, 32'h1000_0007});
      sb.push_back({1'b0, 32'h1000_0000});
      sb.push_back({1'b1, 32'h1000_0001});
      @(posedge clk); #1;
      rd_req = 1'b0;
      rd_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_beat2", 33'(rd_data), 33'h1000_0007);
      rd_ready = 1'b0;
      d[7] = 32'hdeadbeef;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_hold", {rd_valid, rd_data}, {1'b1, 32'h1000_0007});
      end
      rd_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_next", 33'(rd_data), 33'h1000_0000);
      wait_idle();
      d[7] = 32'h1000_0007;

      // Later write seen by the next beat, not the stalled one
      wait_ack();
      rd_addr = 3'd2;
      rd_len  = 3'd1;
      rd_req  = 1'b1;
      sb.push_back({1'b0, 32'h1000_0002});
      sb.push_back({1'b1, 32'hcafef00d});
      @(posedge clk); #1;
      rd_req = 1'b0;
      rd_ready = 1'b0;
      d[3] = 32'hcafef00d;
      @(posedge clk); #1;
      chk("snap_hold", 33'(rd_data), 33'h1000_0002);
      rd_ready = 1'b1;
      wait_idle();
      d[3] = 32'h1000_0003;

      // Request held while busy is ignored until rd_ack returns
      wait_ack();
      rd_addr = 3'd4;
      rd_len  = 3'd2;
      rd_req  = 1'b1;
      sb.push_back({1'b0, 32'h1000_0004});
      sb.push_back({1'b0, 32'h1000_0005});
      sb.push_back({1'b1, 32'h1000_0006});
      @(posedge clk); #1;
      rd_addr = 3'd0;
      rd_len  = 3'd0;
      n = 0;
      while (busy && n < 50) begin
         chk("busy_ack_low", 33'(rd_ack), 33'd0);
         @(posedge clk); #1;
         n++;
      end
      chk("no_accept_on_last", 33'(busy), 33'd0);
      chk("ack_back", 33'(rd_ack), 33'd1);
      sb.push_back({1'b1, 32'h1000_0000});
      @(posedge clk); #1;
      rd_req = 1'b0;
      chk("held_req_taken", {rd_valid, rd_data}, {1'b1, 32'h1000_0000});
      wait_idle();

      // Async reset in the middle of an 8-beat burst
      wait_ack();
      rd_addr = 3'd0;
      rd_len  = 3'd7;
      rd_req  = 1'b1;
      for (int i = 0; i < 8; i++) sb.push_back({i == 7, d[i]});
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(posedge clk); #1;
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_outs", {rd_valid, rd_last, busy, rd_data}, 35'd0);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      do_burst('{addr: 3'd5, len: 3'd0, pat: 8'hff,
                 first: 32'h1000_0005});

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 33'(sb.size()), 33'd0);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
